// File: rtl/decode_pkg.sv
// ============================================================================
// Module      : decode_pkg
// Description : Shared definitions for the instruction-decode stage: opcode
//               values, control-field widths and bit positions, instruction
//               field positions, the bubble constant and the opcode decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    // Recognised opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Instruction field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // Control field widths
    localparam int WB_WIDTH  = 2;
    localparam int MEM_WIDTH = 2;
    localparam int EX_WIDTH  = 4;

    // Bit positions inside the control fields
    localparam int WB_REGWRITE_BIT = 1;
    localparam int WB_MEMTOREG_BIT = 0;
    localparam int MEM_READ_BIT    = 1;
    localparam int MEM_WRITE_BIT   = 0;
    localparam int EX_REGDST_BIT   = 3;
    localparam int EX_ALUOP_MSB    = 2;
    localparam int EX_ALUOP_LSB    = 1;
    localparam int EX_ALUSRC_BIT   = 0;

    // Decoded control bundle carried into ID/EX
    typedef struct packed {
        logic [WB_WIDTH-1:0]  wb;
        logic [MEM_WIDTH-1:0] mem;
        logic [EX_WIDTH-1:0]  ex;
        logic                 illegal;
    } ctrl_t;

    // A bubble carries no control activity and is never flagged illegal
    localparam ctrl_t CTRL_BUBBLE = '0;

    // Map an opcode to its write-back / memory / execute controls
    function automatic ctrl_t decode_opcode(input logic [5:0] opcode);
        ctrl_t c;
        c = CTRL_BUBBLE;
        case (opcode)
            OP_RTYPE: begin
                c.wb[WB_REGWRITE_BIT]   = 1'b1;
                c.ex[EX_REGDST_BIT]     = 1'b1;
                c.ex[EX_ALUOP_MSB]      = 1'b1;
            end
            OP_LW: begin
                c.wb[WB_REGWRITE_BIT]   = 1'b1;
                c.wb[WB_MEMTOREG_BIT]   = 1'b1;
                c.mem[MEM_READ_BIT]     = 1'b1;
                c.ex[EX_ALUSRC_BIT]     = 1'b1;
            end
            OP_SW: begin
                c.mem[MEM_WRITE_BIT]    = 1'b1;
                c.ex[EX_ALUSRC_BIT]     = 1'b1;
            end
            OP_BEQ: begin
                c.ex[EX_ALUOP_LSB]      = 1'b1;
            end
            OP_ADDI: begin
                c.wb[WB_REGWRITE_BIT]   = 1'b1;
                c.ex[EX_ALUSRC_BIT]     = 1'b1;
            end
            default: begin
                c.illegal               = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage : decode_pkg

`default_nettype wire

// File: rtl/decode_regfile.sv
// ============================================================================
// Module      : decode_regfile
// Description : 2**REG_ADDR_WIDTH-entry register file with one synchronous
//               write port and two combinational read ports. Register 0 is
//               hard-wired to zero. Optional write-through bypass is enabled
//               by defining DECODE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_regfile #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      we_i,
    input  logic [REG_ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] raddr1_i,
    input  logic [REG_ADDR_WIDTH-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0]     rdata1_o,
    output logic [DATA_WIDTH-1:0]     rdata2_o
);

    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  w_wrEn;

    // Writes to register 0 are dropped, so entry 0 stays at its reset value
    assign w_wrEn = we_i && (waddr_i != '0);

    // Storage: cleared on reset, written on the rising edge
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wrEn) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

`ifdef DECODE_BYPASS_EN
    // Read ports with write-through: a same-cycle write wins over storage
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        rdata2_o = regs_q[raddr2_i];
        if (w_wrEn && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
        if (w_wrEn && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end
`else
    // Read ports return stored values only; a same-cycle write is not seen
    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];
`endif

endmodule : decode_regfile

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module      : decode_stage
// Description : Instruction-decode stage with ID/EX pipeline register.
//               Decodes the opcode into WB/MEM/EX controls, reads operands,
//               sign-extends the immediate, detects load-use hazards and
//               inserts bubbles on stall, flush or invalid input.
//               Optional macro: DECODE_BYPASS_EN (register-file write-through).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,   // must be >= 16
    parameter int PC_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      inValid,
    input  logic [PC_WIDTH-1:0]       programCounterIn,
    input  logic [31:0]               instruction,
    input  logic                      regWrite,
    input  logic [REG_ADDR_WIDTH-1:0] writeRegister,
    input  logic [DATA_WIDTH-1:0]     writeData,
    input  logic                      flush,
    output logic                      outValid,
    output logic [WB_WIDTH-1:0]       writeBackControl,
    output logic [MEM_WIDTH-1:0]      memAccessControl,
    output logic [EX_WIDTH-1:0]       calculationControl,
    output logic [PC_WIDTH-1:0]       programCounterOut,
    output logic [DATA_WIDTH-1:0]     readData1,
    output logic [DATA_WIDTH-1:0]     readData2,
    output logic [DATA_WIDTH-1:0]     immediateOperand,
    output logic [REG_ADDR_WIDTH-1:0] rs,
    output logic [REG_ADDR_WIDTH-1:0] rt,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic                      illegalOpcode,
    output logic                      pcWrite,
    output logic                      ifIdWrite
);

    // ------------------------------------------------------------------
    // Field extraction (5-bit fields resized to REG_ADDR_WIDTH)
    // ------------------------------------------------------------------
    logic [REG_ADDR_WIDTH-1:0] w_rsIdx;
    logic [REG_ADDR_WIDTH-1:0] w_rtIdx;
    logic [REG_ADDR_WIDTH-1:0] w_rdIdx;
    logic [DATA_WIDTH-1:0]     w_imm;
    logic [DATA_WIDTH-1:0]     w_rdata1;
    logic [DATA_WIDTH-1:0]     w_rdata2;

    assign w_rsIdx = REG_ADDR_WIDTH'(instruction[RS_MSB:RS_LSB]);
    assign w_rtIdx = REG_ADDR_WIDTH'(instruction[RT_MSB:RT_LSB]);
    assign w_rdIdx = REG_ADDR_WIDTH'(instruction[RD_MSB:RD_LSB]);
    assign w_imm   = DATA_WIDTH'(signed'(instruction[IMM_MSB:IMM_LSB]));

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    decode_regfile #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_regfile (
        .clk      (clk),
        .resetN   (resetN),
        .we_i     (regWrite),
        .waddr_i  (writeRegister),
        .wdata_i  (writeData),
        .raddr1_i (w_rsIdx),
        .raddr2_i (w_rtIdx),
        .rdata1_o (w_rdata1),
        .rdata2_o (w_rdata2)
    );

    // ------------------------------------------------------------------
    // ID/EX pipeline register state
    // ------------------------------------------------------------------
    logic                      outValid_q,  outValid_d;
    ctrl_t                     ctrl_q,      ctrl_d;
    logic [PC_WIDTH-1:0]       pc_q;
    logic [DATA_WIDTH-1:0]     rdata1_q;
    logic [DATA_WIDTH-1:0]     rdata2_q;
    logic [DATA_WIDTH-1:0]     imm_q;
    logic [REG_ADDR_WIDTH-1:0] rs_q;
    logic [REG_ADDR_WIDTH-1:0] rt_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;

    logic                      w_loadUse;
    logic                      w_bubble;
    ctrl_t                     w_decoded;

    // Hazard detection and bubble selection for the next ID/EX contents.
    // A load in ID/EX whose destination (non-zero) feeds the instruction in
    // ID must hold IF/ID for one cycle; a flush discards that instruction
    // anyway, so it releases the hold.
    always_comb begin
        w_decoded  = decode_opcode(instruction[OPCODE_MSB:OPCODE_LSB]);
        w_loadUse  = inValid && outValid_q && ctrl_q.mem[MEM_READ_BIT]
                     && (rt_q != '0)
                     && ((rt_q == w_rsIdx) || (rt_q == w_rtIdx));
        w_bubble   = !inValid || flush || w_loadUse;
        outValid_d = !w_bubble;
        ctrl_d     = w_bubble ? CTRL_BUBBLE : w_decoded;
        pcWrite    = flush || !w_loadUse;
        ifIdWrite  = flush || !w_loadUse;
    end

    // ID/EX register: controls follow the bubble decision, data always loads
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            outValid_q <= 1'b0;
            ctrl_q     <= CTRL_BUBBLE;
            pc_q       <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
        end else begin
            outValid_q <= outValid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= programCounterIn;
            rdata1_q   <= w_rdata1;
            rdata2_q   <= w_rdata2;
            imm_q      <= w_imm;
            rs_q       <= w_rsIdx;
            rt_q       <= w_rtIdx;
            rd_q       <= w_rdIdx;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign outValid           = outValid_q;
    assign writeBackControl   = ctrl_q.wb;
    assign memAccessControl   = ctrl_q.mem;
    assign calculationControl = ctrl_q.ex;
    assign illegalOpcode      = ctrl_q.illegal;
    assign programCounterOut  = pc_q;
    assign readData1          = rdata1_q;
    assign readData2          = rdata2_q;
    assign immediateOperand   = imm_q;
    assign rs                 = rs_q;
    assign rt                 = rt_q;
    assign rd                 = rd_q;

endmodule : decode_stage

`default_nettype wire
